hierarchy_lane_sched: RTL

Sequencer that shares a single 8-bit result channel among four result lanes: two input-derived lanes and two parameter constants. Lane 0 is `a` zero-extended, lane 1 is `b` sign-extended, lane 2 is constant C and lane 3 is constant D. On each accepted start command it captures its operands and a lane mask. It then emits each enabled lane, in ascending lane order, over a valid/ready channel, and pulses `done` when finished. It sits between an operand producer and a narrow downstream consumer in the hierarchy test datapath.

---
 rtl/hierarchy_lane_sched.sv | 90 +++++++++
 1 files changed

// File: rtl/hierarchy_lane_sched.sv
// hierarchy_lane_sched: streams the enabled lanes of a captured command over one valid/ready byte channel
module hierarchy_lane_sched #(
  parameter logic signed [7:0] C       = 8'shFF,
  parameter logic        [7:0] D       = 8'hFF,
  parameter int                COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [3:0]         a,
  input  logic [3:0]         b,
  input  logic [3:0]         lane_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [1:0]         out_lane,
  output logic               done,
  output logic [COUNT_W-1:0] xfer_count
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, rem_q, rem_d, src_m;
  logic [1:0] nxt, out_lane_q, out_lane_d;
  logic [7:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, done_q, done_d, accept, xfer;
  logic [COUNT_W-1:0] xfer_count_q, xfer_count_d;
  function automatic logic [1:0] low(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [7:0] val(input logic [1:0] l, input logic [3:0] x, input logic [3:0] y);
    return l == 2'd0 ? {4'b0, x} : l == 2'd1 ? {{4{y[3]}}, y} : l == 2'd2 ? C : D;
  endfunction
  assign start_ready = (state_q == IDLE) && !reset;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_lane    = out_lane_q;
  assign done        = done_q;
  assign xfer_count  = xfer_count_q;
  always_comb begin
    accept       = start_valid && start_ready;
    xfer         = out_valid_q && out_ready;
    src_m        = accept ? lane_mask : rem_q;
    nxt          = low(src_m);
    state_d      = state_q;
    a_d          = accept ? a : a_q;
    b_d          = accept ? b : b_q;
    rem_d        = rem_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_lane_d   = out_lane_q;
    done_d       = 1'b0;
    xfer_count_d = xfer_count_q + COUNT_W'(xfer);
    if ((accept || xfer) && src_m != 4'd0) begin
      state_d     = SEND;
      out_valid_d = 1'b1;
      out_lane_d  = nxt;
      out_data_d  = val(nxt, a_d, b_d);
      rem_d       = src_m & ~(4'b1 << nxt);
    end else if (accept || xfer) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_data_d  = 8'd0;
      done_d      = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      rem_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_lane_q   <= '0;
      done_q       <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rem_q        <= rem_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_lane_q   <= out_lane_d;
      done_q       <= done_d;
      xfer_count_q <= xfer_count_d;
    end
  end
endmodule
